uart_io: RTL
============

// Module: uart_io
// PURPOSE
//  Memory-mapped 8N1 UART peripheral for the nano6502 I/O page ($FE00-$FEFF, bank 1).
//  Consumes uart_cs from the address decoder and exposes TX data, RX data and status registers.
//  Contains a baud-rate TX shifter, an oversampled RX deserialiser and a small RX FIFO.
//  data_o is returned combinationally into the CPU read mux.
// PARAMETERS
//  CLK_HZ       27000000  system clock frequency
//  BAUD         115200    line rate; DIV = CLK_HZ/BAUD, integer-truncated (234 at defaults)
//  RX_DEPTH     16        RX FIFO entries, power of two, >= 2
// PORTS
//  clk_i        in   1  system clock
//  rst_n_i      in   1  asynchronous active-low reset
//  uart_cs      in   1  page select from address decoder
//  R_W_n        in   1  CPU bus direction: 1 = read, 0 = write
//  addr_i       in   8  low address byte (register offset within page)
//  data_i       in   8  CPU write data
//  data_o       out  8  register read data, combinational
//  uart_rx_i    in   1  serial input, asynchronous to clk_i
//  uart_tx_o    out  1  serial output
//  rx_irq_o     out  1  high while RX FIFO not empty
// BEHAVIOUR
//  Bus: each clk_i cycle with uart_cs=1 is exactly one access; side effects occur at that clock edge.
//  Register map (offset = addr_i):
//   $00 W: TX data. Accepted only if tx_ready=1; otherwise dropped silently.
//   $00 R: RX FIFO head. Pops at the clock edge. When empty: reads $00, no pop.
//   $01 R: status. b0 rx_avail, b1 tx_ready, b2 rx_overrun, b3 frame_err, b7..b4 = 0.
//   $01 W: writing 1 to b2 or b3 clears that sticky flag; all other bits ignored.
//   All other offsets: read $00, writes ignored.
//  data_o is $00 whenever uart_cs=0.
//  Reset values: uart_tx_o=1, tx_ready=1, FIFO empty, rx_irq_o=0, flags=0, data_o=$00.
//  TX:
//   - On an accepted write, tx_ready drops at the next edge.
//   - Start bit (0) is driven from the cycle after the write; then 8 data bits LSB first, then stop bit (1).
//   - Each bit lasts DIV cycles.
//   - tx_ready returns to 1 after exactly 10*DIV cycles; a back-to-back write is then accepted.
//  RX:
//   - uart_rx_i passes through a 2-flop synchroniser.
//   - IDLE -> START on a synchronised falling edge.
//   - START samples at DIV/2: if high (glitch), return to IDLE; otherwise go to DATA.
//   - DATA takes 8 samples spaced DIV apart, LSB first, then STOP.
//   - STOP sample high: push the byte. STOP sample low: set frame_err, discard the byte, return to IDLE.
//   - The receiver rearms immediately after the stop-bit sample.
//  FIFO:
//   - Push while full is dropped and sets rx_overrun.
//   - Push and pop in the same cycle when full: both succeed, no overrun.
//   - Push and pop in the same cycle when empty: pop ignored, push succeeds.
//   - Pointers wrap modulo RX_DEPTH; occupancy counter is log2(RX_DEPTH)+1 bits.
//   - rx_avail = rx_irq_o = (count != 0), registered from state.
//  Status flags: if a set and a clear of the same flag occur in the same cycle, set wins.
//  Reset mid-frame: TX aborts with the line forced high; RX returns to IDLE; FIFO is emptied.
// STRUCTURE
//  Shared package/include nano6502_defs:
//   - register offsets UART_DATA=$00, UART_STAT=$01
//   - status bit indices
//   - I/O bank number for the UART ($01)
//  Sub-module uart_rx_fifo (width 8, depth RX_DEPTH):
//   - ports push/pop/din/dout/full/empty/count
//   - head is visible combinationally on dout
//  TX shifter, RX FSM and baud counters stay in uart_io.
// TESTING
//  1. Reset, no access -> uart_tx_o=1, status read = $02, data read = $00, rx_irq_o=0.
//  2. Write $00<=$A5 -> line 0,1,0,1,0,0,1,0,1,1, each bit 234 clk; status b1=0 until cycle 2340 after write.
//  3. Drive frame $3C on uart_rx_i -> rx_irq_o=1, status=$03; read $00 returns $3C; status then $02.
//  4. Send 17 bytes without reading -> first 16 read back in order, 17th lost; status b2=1.
//     Write $01<=$04 -> b2 clears.
//  5. Frame with stop bit 0 -> FIFO unchanged, status b3=1.
//     Then 1-cycle low glitch on rx -> no byte pushed, no flag set.
//  6. Assert rst_n_i mid-TX and mid-RX -> tx line 1 immediately, FIFO empty.
//     Next frame $81 is received correctly.

Source files
------------

// File: rtl/nano6502_defs_pkg.sv
// Shared nano6502 I/O definitions: UART register offsets, status bit layout,
// I/O bank number and RX FSM state encodings.
package nano6502_defs;

   localparam logic [7:0] UART_DATA = 8'h00;
   localparam logic [7:0] UART_STAT = 8'h01;
   localparam logic [7:0] UART_BANK = 8'h01;

   localparam int STAT_RX_AVAIL   = 0;
   localparam int STAT_TX_READY   = 1;
   localparam int STAT_RX_OVERRUN = 2;
   localparam int STAT_FRAME_ERR  = 3;

   localparam logic [1:0] RX_IDLE  = 2'd0;
   localparam logic [1:0] RX_START = 2'd1;
   localparam logic [1:0] RX_DATA  = 2'd2;
   localparam logic [1:0] RX_STOP  = 2'd3;

   function automatic logic [7:0] pack_status(input logic rx_avail, input logic tx_ready,
                                              input logic overrun, input logic frame_err);
      logic [7:0] s;
      s = 8'h00;
      s[STAT_RX_AVAIL]   = rx_avail;
      s[STAT_TX_READY]   = tx_ready;
      s[STAT_RX_OVERRUN] = overrun;
      s[STAT_FRAME_ERR]  = frame_err;
      return s;
   endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Receive FIFO for uart_io: circular buffer with an occupancy counter, head
// visible combinationally on dout. A push into a full FIFO is dropped unless a
// pop happens in the same cycle.
module uart_rx_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                       clk_i,
   input  logic                       rst_n_i,
   input  logic                       push,
   input  logic                       pop,
   input  logic [WIDTH-1:0]           din,
   output logic [WIDTH-1:0]           dout,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     count
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             push_ok;
   logic             pop_ok;

   assign empty   = (count == '0);
   assign full    = (count == (AW+1)'(DEPTH));
   assign pop_ok  = pop && !empty;
   assign push_ok = push && (!full || pop);
   assign dout    = mem[rd_ptr];

   // NOTE: storage has no reset; only pointers and count define validity.
   always_ff @(posedge clk_i) begin
      if (push_ok) mem[wr_ptr] <= din;
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
         count <= count + {{AW{1'b0}}, push_ok} - {{AW{1'b0}}, pop_ok};
      end
   end

endmodule

// File: rtl/uart_io.sv
// Memory-mapped 8N1 UART for the nano6502 I/O page: TX shifter, oversampled
// RX deserialiser feeding uart_rx_fifo, sticky status flags, combinational read mux.
module uart_io
   import nano6502_defs::*;
#(
   parameter int CLK_HZ   = 27000000,
   parameter int BAUD     = 115200,
   parameter int RX_DEPTH = 16
) (
   input  logic       clk_i,
   input  logic       rst_n_i,
   input  logic       uart_cs,
   input  logic       R_W_n,
   input  logic [7:0] addr_i,
   input  logic [7:0] data_i,
   output logic [7:0] data_o,
   input  logic       uart_rx_i,
   output logic       uart_tx_o,
   output logic       rx_irq_o
);
   localparam int DIV  = CLK_HZ / BAUD;
   localparam int HALF = DIV / 2;
   localparam int CW   = $clog2(DIV);
   localparam logic [CW-1:0] DIV_M1  = CW'(DIV - 1);
   localparam logic [CW-1:0] HALF_M1 = CW'(HALF - 1);

   logic       bus_rd, bus_wr, tx_wr, stat_wr, rx_pop;
   logic       tx_busy, tx_ready;
   logic [9:0] tx_shift;
   logic [CW-1:0] tx_cnt;
   logic [3:0] tx_bit;

   logic       rx_meta, rx_sync, rx_last, rx_fall;
   logic [1:0] rx_state;
   logic [CW-1:0] rx_cnt;
   logic [2:0] rx_bit;
   logic [7:0] rx_shift;
   logic       stop_sample, rx_push, frame_set, overrun_set;
   logic       rx_overrun, frame_err;

   logic [7:0] fifo_dout;
   logic       fifo_full, fifo_empty;
   logic [$clog2(RX_DEPTH):0] fifo_count;

   assign bus_rd   = uart_cs && R_W_n;
   assign bus_wr   = uart_cs && !R_W_n;
   assign tx_ready = !tx_busy;
   assign tx_wr    = bus_wr && (addr_i == UART_DATA) && tx_ready;
   assign stat_wr  = bus_wr && (addr_i == UART_STAT);
   assign rx_pop   = bus_rd && (addr_i == UART_DATA);

   // Frame is {stop, data, start}; shifting right with 1-fill leaves the line idle-high.
   assign uart_tx_o = tx_shift[0];

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         tx_shift <= '1;
         tx_busy  <= 1'b0;
         tx_cnt   <= '0;
         tx_bit   <= '0;
      end else if (tx_wr) begin
         tx_shift <= {1'b1, data_i, 1'b0};
         tx_busy  <= 1'b1;
         tx_cnt   <= '0;
         tx_bit   <= '0;
      end else if (tx_busy) begin
         if (tx_cnt == DIV_M1) begin
            tx_cnt   <= '0;
            tx_shift <= {1'b1, tx_shift[9:1]};
            if (tx_bit == 4'd9) tx_busy <= 1'b0;
            else                tx_bit  <= tx_bit + 1'b1;
         end else begin
            tx_cnt <= tx_cnt + 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         rx_meta <= 1'b1;
         rx_sync <= 1'b1;
         rx_last <= 1'b1;
      end else begin
         rx_meta <= uart_rx_i;
         rx_sync <= rx_meta;
         rx_last <= rx_sync;
      end
   end

   assign rx_fall     = rx_last && !rx_sync;
   assign stop_sample = (rx_state == RX_STOP) && (rx_cnt == DIV_M1);
   assign rx_push     = stop_sample && rx_sync;
   assign frame_set   = stop_sample && !rx_sync;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         rx_state <= RX_IDLE;
         rx_cnt   <= '0;
         rx_bit   <= '0;
         rx_shift <= '0;
      end else begin
         case (rx_state)
            RX_IDLE: if (rx_fall) begin
               rx_state <= RX_START;
               rx_cnt   <= '0;
            end
            RX_START: if (rx_cnt == HALF_M1) begin
               rx_cnt   <= '0;
               rx_bit   <= '0;
               rx_state <= rx_sync ? RX_IDLE : RX_DATA;
            end else rx_cnt <= rx_cnt + 1'b1;
            RX_DATA: if (rx_cnt == DIV_M1) begin
               rx_cnt   <= '0;
               rx_shift <= {rx_sync, rx_shift[7:1]};
               rx_bit   <= rx_bit + 1'b1;
               if (rx_bit == 3'd7) rx_state <= RX_STOP;
            end else rx_cnt <= rx_cnt + 1'b1;
            RX_STOP: if (rx_cnt == DIV_M1) begin
               rx_cnt   <= '0;
               rx_state <= RX_IDLE;
            end else rx_cnt <= rx_cnt + 1'b1;
            default: rx_state <= RX_IDLE;
         endcase
      end
   end

   uart_rx_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_fifo (
      .clk_i   (clk_i),
      .rst_n_i (rst_n_i),
      .push    (rx_push),
      .pop     (rx_pop),
      .din     (rx_shift),
      .dout    (fifo_dout),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .count   (fifo_count)
   );

   assign overrun_set = rx_push && fifo_full && !rx_pop;
   assign rx_irq_o    = (fifo_count != '0);

   // Set has priority over a same-cycle clear.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         rx_overrun <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         rx_overrun <= overrun_set || (rx_overrun && !(stat_wr && data_i[STAT_RX_OVERRUN]));
         frame_err  <= frame_set   || (frame_err  && !(stat_wr && data_i[STAT_FRAME_ERR]));
      end
   end

   // NOTE: default assignment first keeps this block free of inferred latches.
   always_comb begin
      data_o = 8'h00;
      if (bus_rd) begin
         case (addr_i)
            UART_DATA: data_o = fifo_empty ? 8'h00 : fifo_dout;
            UART_STAT: data_o = pack_status(rx_irq_o, tx_ready, rx_overrun, frame_err);
            default:   data_o = 8'h00;
         endcase
      end
   end

endmodule
